p2_btn_link_rx: RTL



---
 rtl/p2_link_pkg.sv | 26 ++
 rtl/p2_btn_link_rx_sync_2ff.sv | 22 ++
 rtl/p2_btn_link_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/p2_link_pkg.sv
// Shared definitions for the player-2 button link.
// The slave-side transmitter uses the same frame layout and parity rule.
package p2_link_pkg;

   localparam int FRAME_DATA_BITS = 5;

   localparam int BIT_UP     = 0;
   localparam int BIT_DOWN   = 1;
   localparam int BIT_LEFT   = 2;
   localparam int BIT_RIGHT  = 3;
   localparam int BIT_ATTACK = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Odd parity: data bits plus the returned bit always hold an odd number of 1s.
   function automatic logic odd_parity(input logic [FRAME_DATA_BITS-1:0] data);
      return ~(^data);
   endfunction

endpackage

// File: rtl/p2_btn_link_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a UART-style idle line does not look like a start bit.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/p2_btn_link_rx.sv
// Player-2 button link receiver: framed, odd-parity serial input decoded into
// registered button outputs, with link-loss timeout that releases all buttons.
module p2_btn_link_rx
   import p2_link_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 868,
   parameter int TIMEOUT_CYCLES = 5000000,
   parameter int ERR_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rx_pin,
   output logic             player2UpBtn,
   output logic             player2DownBtn,
   output logic             player2LeftBtn,
   output logic             player2RightBtn,
   output logic             player2AttackBtn,
   output logic             frame_valid,
   output logic             parity_err,
   output logic             frame_err,
   output logic             link_up,
   output logic [ERR_W-1:0] err_count
);

   localparam int TIMER_W = $clog2(CLKS_PER_BIT);
   localparam int TO_W    = $clog2(TIMEOUT_CYCLES);

   localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]         LAST_IDX  = 3'(FRAME_DATA_BITS - 1);

   logic                       rx_s;
   rx_state_t                  state;
   rx_state_t                  state_next;
   logic [TIMER_W-1:0]         timer;
   logic [2:0]                 bit_idx;
   logic [FRAME_DATA_BITS-1:0] shift;
   logic                       par_bit;
   logic [FRAME_DATA_BITS-1:0] btn;
   logic [TO_W-1:0]            to_cnt;

   logic timer_clr;
   logic enter_data;
   logic sample_data;
   logic sample_par;
   logic stop_eval;
   logic good_frame;
   logic bad_stop;
   logic bad_par;
   logic timed_out;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_pin),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Each non-idle state waits on the bit timer, then samples mid-bit.
   always_comb begin
      state_next  = state;
      timer_clr   = 1'b0;
      enter_data  = 1'b0;
      sample_data = 1'b0;
      sample_par  = 1'b0;
      stop_eval   = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               timer_clr  = 1'b1;
            end
         end
         START: begin
            if (timer == HALF_LAST) begin
               timer_clr = 1'b1;
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  enter_data = 1'b1;
               end
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_clr   = 1'b1;
               sample_data = 1'b1;
               if (bit_idx == LAST_IDX) begin
                  state_next = PARITY;
               end
            end
         end
         PARITY: begin
            if (timer == BIT_LAST) begin
               timer_clr  = 1'b1;
               sample_par = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (timer == BIT_LAST) begin
               timer_clr  = 1'b1;
               stop_eval  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A bad stop bit outranks a parity failure.
   assign bad_stop   = stop_eval && !rx_s;
   assign bad_par    = stop_eval && rx_s && (odd_parity(shift) != par_bit);
   assign good_frame = stop_eval && rx_s && (odd_parity(shift) == par_bit);
   assign timed_out  = (to_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
      end else begin
         if (state == IDLE || timer_clr) begin
            timer <= '0;
         end else begin
            timer <= timer + TIMER_W'(1);
         end
         if (enter_data) begin
            bit_idx <= '0;
         end else if (sample_data) begin
            bit_idx <= bit_idx + 3'd1;
         end
         // LSB arrives first, so shifting in from the top leaves d0 in bit 0.
         if (sample_data) begin
            shift <= {rx_s, shift[FRAME_DATA_BITS-1:1]};
         end
         if (sample_par) begin
            par_bit <= rx_s;
         end
      end
   end

   // A good frame landing on the timeout cycle still wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn         <= '0;
         link_up     <= 1'b0;
         to_cnt      <= '0;
         frame_valid <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_valid <= good_frame;
         parity_err  <= bad_par;
         frame_err   <= bad_stop;
         if (good_frame) begin
            btn     <= shift;
            link_up <= 1'b1;
            to_cnt  <= '0;
         end else begin
            if (timed_out) begin
               btn     <= '0;
               link_up <= 1'b0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
         if ((bad_par || bad_stop) && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

   assign player2UpBtn     = btn[BIT_UP];
   assign player2DownBtn   = btn[BIT_DOWN];
   assign player2LeftBtn   = btn[BIT_LEFT];
   assign player2RightBtn  = btn[BIT_RIGHT];
   assign player2AttackBtn = btn[BIT_ATTACK];

endmodule
